// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// size/alignment helpers used by the stage and its load formatter.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // The spare MemSize code 2'b11 behaves as a word access.
    function automatic mem_size_e decode_size(input logic [1:0] raw);
        mem_size_e size;
        unique case (raw)
            2'b00:   size = SZ_BYTE;
            2'b01:   size = SZ_HALF;
            default: size = SZ_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input logic [1:0] addr, input mem_size_e size);
        logic ok;
        unique case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (addr[0] == 1'b0);
            default: ok = (addr == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load formatter: picks the addressed byte/half lane out of the memory word
// and zero- or sign-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane selection and extension.
    always_comb begin
        unique case (addr)
            2'b00:   lane_byte = rdata[7:0];
            2'b01:   lane_byte = rdata[15:8];
            2'b10:   lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = addr[1] ? rdata[31:16] : rdata[15:0];

        unique case (size)
            SZ_BYTE: data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
            SZ_HALF: data = {{16{sign_ext & lane_half[15]}}, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory transactions for loads/stores,
// stalls upstream while one is outstanding and loads the MEM/WB register.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        ALUresult,
    input  logic [31:0]        StoreData,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [1:0]         MemSize,
    input  logic               MemSigned,
    input  logic               RegWrite,
    input  logic               MemtoReg,
    input  logic [4:0]         WriteReg,
    output logic               stall,
    mem_access_stage_if.master dmem,
    output logic               wb_valid,
    output logic               wb_RegWrite,
    output logic               wb_MemtoReg,
    output logic [4:0]         wb_WriteReg,
    output logic [31:0]        wb_ALUresult,
    output logic [31:0]        wb_ReadData,
    output logic               misaligned
);

    state_e      state_q, state_d;
    mem_size_e   size_d;
    logic        is_mem;
    logic        aligned;
    logic        accept;
    logic        reject;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_read;
    mem_size_e   lat_size;
    logic        lat_signed;
    logic        lat_regwrite;
    logic        lat_memtoreg;
    logic [4:0]  lat_writereg;
    logic [31:0] load_data;

    // Decode the incoming slot: memory op, alignment, and whether it starts
    // a transaction or is rejected as misaligned.
    always_comb begin
        size_d  = decode_size(MemSize);
        is_mem  = MemRead | MemWrite;
        aligned = is_aligned(ALUresult[1:0], size_d);
        accept  = (state_q == ST_IDLE) && in_valid && is_mem && aligned;
        reject  = (state_q == ST_IDLE) && in_valid && is_mem && !aligned;
    end

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        unique case (size_d)
            SZ_BYTE: begin
                be_d    = 4'b0001 << ALUresult[1:0];
                wdata_d = {4{StoreData[7:0]}};
            end
            SZ_HALF: begin
                be_d    = 4'b0011 << {ALUresult[1], 1'b0};
                wdata_d = {2{StoreData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = StoreData;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: enter ACCESS on an accepted op, leave on ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ACCESS;
            ST_ACCESS: if (dmem.dmem_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bus fields come only from latched state; stall also
    // depends on the incoming slot and ack. Reset forces stall low at once.
    always_comb begin
        stall           = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_be    = '0;
        dmem.dmem_wdata = '0;
        unique case (state_q)
            ST_IDLE: stall = accept;
            ST_ACCESS: begin
                stall           = ~dmem.dmem_ack;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = lat_we;
                dmem.dmem_addr  = {lat_addr[31:2], 2'b00};
                dmem.dmem_be    = lat_be;
                dmem.dmem_wdata = lat_wdata;
            end
            default: stall = 1'b0;
        endcase
        if (reset) stall = 1'b0;
    end

    // Capture the accepted op so the bus stays stable while memory responds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr     <= '0;
            lat_be       <= '0;
            lat_wdata    <= '0;
            lat_we       <= 1'b0;
            lat_read     <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_signed   <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_writereg <= '0;
        end else if (accept) begin
            lat_addr     <= ALUresult;
            lat_be       <= be_d;
            lat_wdata    <= wdata_d;
            lat_we       <= MemWrite;
            lat_read     <= MemRead & ~MemWrite;
            lat_size     <= size_d;
            lat_signed   <= MemSigned;
            lat_regwrite <= RegWrite;
            lat_memtoreg <= MemtoReg;
            lat_writereg <= WriteReg;
        end
    end

    load_align u_load_align (
        .rdata    (dmem.dmem_rdata),
        .addr     (lat_addr[1:0]),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .data     (load_data)
    );

    // MEM/WB register: a bubble unless a non-memory op, a misaligned op or
    // a completing transaction retires this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_WriteReg  <= '0;
            wb_ALUresult <= '0;
            wb_ReadData  <= '0;
            misaligned   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_WriteReg  <= '0;
            wb_ALUresult <= '0;
            wb_ReadData  <= '0;
            misaligned   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid && !is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_RegWrite  <= RegWrite;
                        wb_MemtoReg  <= MemtoReg;
                        wb_WriteReg  <= WriteReg;
                        wb_ALUresult <= ALUresult;
                    end else if (reject) begin
                        wb_valid     <= 1'b1;
                        wb_WriteReg  <= WriteReg;
                        wb_ALUresult <= ALUresult;
                        misaligned   <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (dmem.dmem_ack) begin
                        wb_valid     <= 1'b1;
                        wb_RegWrite  <= lat_regwrite;
                        wb_MemtoReg  <= lat_memtoreg;
                        wb_WriteReg  <= lat_writereg;
                        wb_ALUresult <= lat_addr;
                        wb_ReadData  <= lat_read ? load_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
